// File: rtl/vend_dispense_ctrl_if.sv
// Vending dispense controller bus: coin path, sale
// handshake, actuator drives and fault status.
interface vend_dispense_ctrl_if;
  logic [1:0] coin_in;
  logic [1:0] coin_out;
  logic       coin_reject;
  logic       sell;
  logic [1:0] change;
  logic       motor_on;
  logic       item_sense;
  logic       chg_eject;
  logic       busy;
  logic       fault;
  logic       fault_clr;

  modport master (
    output coin_in,
    output sell,
    output change,
    output item_sense,
    output fault_clr,
    input  coin_out,
    input  coin_reject,
    input  motor_on,
    input  chg_eject,
    input  busy,
    input  fault
  );

  modport slave (
    input  coin_in,
    input  sell,
    input  change,
    input  item_sense,
    input  fault_clr,
    output coin_out,
    output coin_reject,
    output motor_on,
    output chg_eject,
    output busy,
    output fault
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: motor, item-drop wait, change
// ejection and coin blocking after each sale.
module vend_dispense_ctrl #(
  parameter int DISP_CYCLES = 4,
  parameter int CHG_CYCLES  = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  vend_dispense_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DISP  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHG   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [CNT_W-1:0] DISP_LAST =
    CNT_W'(DISP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHG_LAST =
    CNT_W'(CHG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] timer_inc;
  logic [1:0]       chg_cnt_q, chg_cnt_d;
  logic             item_seen_q, item_seen_d;
  logic             motor_on_q, motor_on_d;
  logic             chg_eject_q, chg_eject_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             coin_reject_q, coin_reject_d;
  logic             coin_valid;
  logic             chg_left;

  assign coin_valid = (bus.coin_in == 2'b01) ||
                      (bus.coin_in == 2'b10);
  assign chg_left   = (chg_cnt_q != 2'd0);

  // Saturating increment of the shared cycle timer
  always_comb begin
    timer_inc = timer_q;
    if (timer_q != CNT_MAX) begin
      timer_inc = timer_q + 1'b1;
    end
  end

  // Next-state, timer, change count and item latch
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_inc;
    chg_cnt_d   = chg_cnt_q;
    item_seen_d = item_seen_q;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (bus.sell) begin
          state_d     = S_DISP;
          chg_cnt_d   = bus.change;
          item_seen_d = 1'b0;
        end
      end
      S_DISP: begin
        if (bus.item_sense) begin
          item_seen_d = 1'b1;
        end
        if (timer_q == DISP_LAST) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (item_seen_q || bus.item_sense) begin
          timer_d = '0;
          state_d = chg_left ? S_CHG : S_IDLE;
        end else if (timer_q == TMO_LAST) begin
          timer_d = '0;
          state_d = S_FAULT;
        end
      end
      S_CHG: begin
        if (timer_q == CHG_LAST) begin
          timer_d = '0;
          state_d = S_GAP;
          if (chg_left) begin
            chg_cnt_d = chg_cnt_q - 2'd1;
          end
        end
      end
      S_GAP: begin
        if (timer_q == CHG_LAST) begin
          timer_d = '0;
          state_d = chg_left ? S_CHG : S_IDLE;
        end
      end
      S_FAULT: begin
        timer_d = '0;
        if (bus.fault_clr) begin
          state_d   = S_IDLE;
          chg_cnt_d = 2'd0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        timer_d   = '0;
        chg_cnt_d = 2'd0;
      end
    endcase
  end

  // Outputs registered from the next state so they
  // change on the same edge as the state itself
  always_comb begin
    motor_on_d    = (state_d == S_DISP);
    chg_eject_d   = (state_d == S_CHG);
    busy_d        = (state_d != S_IDLE);
    fault_d       = (state_d == S_FAULT);
    coin_reject_d = busy_q && coin_valid;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      chg_cnt_q     <= 2'd0;
      item_seen_q   <= 1'b0;
      motor_on_q    <= 1'b0;
      chg_eject_q   <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      chg_cnt_q     <= chg_cnt_d;
      item_seen_q   <= item_seen_d;
      motor_on_q    <= motor_on_d;
      chg_eject_q   <= chg_eject_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Coins pass straight through unless blocked
  assign bus.coin_out =
    (busy_q || bus.coin_in == 2'b11) ? 2'b00
                                     : bus.coin_in;
  assign bus.coin_reject = coin_reject_q;
  assign bus.motor_on    = motor_on_q;
  assign bus.chg_eject   = chg_eject_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;

endmodule
